// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: memory-handshake FSM
// states and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in ID/EX writes a register that the
// instruction in IF/ID reads. Writes to x0 never create a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs1_addr_i,
  input  logic [4:0] ifid_rs2_addr_i,
  input  logic [4:0] idex_rd_addr_i,
  input  logic       idex_mem_read_i,
  output logic       lu_hit_o
);

  assign lu_hit_o = idex_mem_read_i
                  & (idex_rd_addr_i != REG_X0)
                  & ((idex_rd_addr_i == ifid_rs1_addr_i) | (idex_rd_addr_i == ifid_rs2_addr_i));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/bubble controller: runs the data-memory handshake for EX/MEM
// and converts memory waits and load-use hazards into pipeline enables.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       IFID_RS1Addr_i,
  input  logic [4:0]       IFID_RS2Addr_i,
  input  logic [4:0]       IDEX_RdAddr_i,
  input  logic             IDEX_MemRead_i,
  input  logic             EXMEM_MemRead_i,
  input  logic             EXMEM_MemWrite_i,
  input  logic             mem_ack_i,
  output logic             mem_enable_o,
  output logic             mem_write_o,
  output logic             stall_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             noop_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] memstall_cnt_o,
  output logic [CNT_W-1:0] loaduse_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  memstall_cnt_q, memstall_cnt_d;
  logic [CNT_W-1:0]  loaduse_cnt_q, loaduse_cnt_d;

  logic mem_op;
  logic lu_hit;
  logic idle_req;
  logic wait_timeout;

  hazard_detect u_hazard_detect (
    .ifid_rs1_addr_i (IFID_RS1Addr_i),
    .ifid_rs2_addr_i (IFID_RS2Addr_i),
    .idex_rd_addr_i  (IDEX_RdAddr_i),
    .idex_mem_read_i (IDEX_MemRead_i),
    .lu_hit_o        (lu_hit)
  );

  assign mem_op       = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign idle_req     = (state_q == ST_IDLE) & start_i & mem_op;
  // The counter holds completed WAIT cycles, so the current cycle is the last allowed one here.
  assign wait_timeout = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_req) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_DONE;
        end else if (wait_timeout) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_o      = idle_req | (state_q == ST_WAIT) | (state_q == ST_ERR);
  assign mem_enable_o = idle_req | (state_q == ST_WAIT);
  assign mem_write_o  = mem_enable_o & EXMEM_MemWrite_i;
  // A memory stall masks the hazard; it is re-evaluated once the pipeline moves again.
  assign noop_o       = start_i & lu_hit & ~stall_o;
  assign pc_write_o   = ~stall_o & ~noop_o;
  assign ifid_write_o = ~stall_o & ~noop_o;
  assign busy_o       = (state_q != ST_IDLE);
  assign err_o        = (state_q == ST_ERR);

  always_comb begin
    memstall_cnt_d = memstall_cnt_q;
    loaduse_cnt_d  = loaduse_cnt_q;
    if (stall_o && (memstall_cnt_q != '1)) begin
      memstall_cnt_d = memstall_cnt_q + CNT_W'(1);
    end
    if (noop_o && (loaduse_cnt_q != '1)) begin
      loaduse_cnt_d = loaduse_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      memstall_cnt_q <= '0;
      loaduse_cnt_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      memstall_cnt_q <= memstall_cnt_d;
      loaduse_cnt_q  <= loaduse_cnt_d;
    end
  end

  assign memstall_cnt_o = memstall_cnt_q;
  assign loaduse_cnt_o  = loaduse_cnt_q;

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Central stall and bubble controller for the 5-stage RISC-V pipeline. Produces the `stall_i` hold signal consumed by every pipeline register, including ID/EX. Produces the PC/IF-ID write enables and the ID/EX bubble request for load-use hazards. Runs the request/acknowledge handshake to the multi-cycle data memory for the instruction sitting in EX/MEM.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: maximum cycles in WAIT before the error state.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: pipeline run enable. When 0, no new memory request and no load-use bubble.
- `IFID_RS1Addr_i` in 5: rs1 of the instruction in IF/ID.
- `IFID_RS2Addr_i` in 5: rs2 of the instruction in IF/ID.
- `IDEX_RdAddr_i` in 5: rd of the instruction in ID/EX.
- `IDEX_MemRead_i` in 1: instruction in ID/EX is a load.
- `EXMEM_MemRead_i` in 1: instruction in EX/MEM reads memory.
- `EXMEM_MemWrite_i` in 1: instruction in EX/MEM writes memory.
- `mem_ack_i` in 1: data memory completion, single-cycle pulse.
- `mem_enable_o` out 1: data memory request, held high until ack.
- `mem_write_o` out 1: request is a write.
- `stall_o` out 1: freeze all four pipeline registers and the PC.
- `pc_write_o` out 1: PC update enable.
- `ifid_write_o` out 1: IF/ID update enable.
- `noop_o` out 1: force zero control signals into ID/EX this cycle.
- `busy_o` out 1: FSM not in IDLE.
- `err_o` out 1: memory timeout, sticky.
- `memstall_cnt_o` out CNT_W: cycles with `stall_o`=1.
- `loaduse_cnt_o` out CNT_W: cycles with `noop_o`=1.

## Operation
- `mem_op` = `EXMEM_MemRead_i` | `EXMEM_MemWrite_i`.
- `lu_hit` = `IDEX_MemRead_i` & (`IDEX_RdAddr_i`≠0) & (`IDEX_RdAddr_i`==`IFID_RS1Addr_i` | `IDEX_RdAddr_i`==`IFID_RS2Addr_i`).
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE → WAIT when `start_i` & `mem_op`.
- WAIT → DONE on `mem_ack_i`.
- WAIT → ERR when the wait counter reaches `TIMEOUT_CYCLES`. If ack and timeout occur in the same cycle, ack wins.
- DONE → IDLE unconditionally.
- ERR holds until `rst_i`.
- `mem_op` in DONE is ignored. It is the already-serviced instruction, which leaves EX/MEM this cycle.
- `stall_o` = (IDLE & `start_i` & `mem_op`) | WAIT | ERR. This is a Mealy output: the pipeline freezes in the same cycle the memory op is detected.
- `mem_enable_o` = (IDLE & `start_i` & `mem_op`) | WAIT.
- `mem_write_o` = `mem_enable_o` & `EXMEM_MemWrite_i`. This follows the frozen EX/MEM contents.
- `noop_o` = `start_i` & `lu_hit` & ~`stall_o`. Memory stall dominates a load-use hazard: the hazard is re-evaluated after the stall ends.
- `pc_write_o` = ~`stall_o` & ~`noop_o`.
- `ifid_write_o` = ~`stall_o` & ~`noop_o`.
- `start_i` falling while in WAIT does not abort the request. The FSM still completes through DONE.
- `busy_o` = state≠IDLE.
- `err_o` = ERR.
- Wait counter: cleared on entry to WAIT, increments each WAIT cycle.
- Both performance counters saturate at all-ones. They never wrap.

## Timing
- Reset values, effective the cycle after `rst_i` is sampled high: state IDLE, wait counter 0, both performance counters 0, `err_o`=0, `busy_o`=0. Combinational outputs then follow the IDLE equations.
- Reset while in WAIT or ERR: return to IDLE. `mem_enable_o` drops the following cycle. Any pending ack is ignored.
- Memory access with ack arriving N cycles after request: `stall_o` is high for N+1 cycles (IDLE detect cycle plus N WAIT cycles). DONE adds one advance cycle with `stall_o`=0.
- Back-to-back memory ops: the second op is detected in the IDLE cycle that follows DONE.
- Load-use bubble: exactly one cycle, with no memory stall active. The next cycle `lu_hit` drops because the load has moved to EX/MEM.
- An ack arriving while in IDLE or DONE is ignored.

## Structure
- Shared package/header `pipe_ctrl_pkg`: 2-bit state encodings (IDLE=0, WAIT=1, DONE=2, ERR=3) and the x0 register index constant.
- One sub-module, `hazard_detect`: purely combinational `lu_hit` compare.
- Everything else (FSM, counters, output equations) lives in the top.

## Test plan
- Reset, then idle with `start_i`=1 and no mem_op → `stall_o`=0, `pc_write_o`=1, `noop_o`=0, counters 0.
- EX/MEM load, ack after 3 cycles → `stall_o` high 4 cycles, `mem_enable_o` high 4 cycles with `mem_write_o`=0, DONE cycle `stall_o`=0, `memstall_cnt_o`=4.
- ID/EX load with rd=5 and IF/ID rs2=5 → `noop_o`=1, `pc_write_o`=0, `ifid_write_o`=0 for one cycle, `loaduse_cnt_o`=1. Same case with rd=0 → no bubble.
- Store in EX/MEM concurrent with a load-use hit → `noop_o`=0 during the stall, `mem_write_o`=1. After DONE, if the hazard remains, `noop_o`=1 for one cycle.
- `TIMEOUT_CYCLES`=8, no ack → ERR after 8 WAIT cycles, `err_o`=1, `stall_o` stuck 1. Then `rst_i` → IDLE, `err_o`=0, counters 0.
- `rst_i` asserted in the 2nd WAIT cycle, then a late ack → state IDLE, `mem_enable_o`=0, ack has no effect.
